// File: rtl/hx711_pkg.sv
// Shared constants for the HX711 capture core: state encoding, status/irq bit indices.
package hx711_pkg;

  localparam int DATA_BITS = 24;

  localparam int STS_BUSY    = 0;
  localparam int STS_DONE    = 1;
  localparam int STS_TIMEOUT = 2;
  localparam int STS_READY   = 3;
  localparam int STS_CNT_LSB = 4;

  localparam int IRQ_DONE    = 0;
  localparam int IRQ_TIMEOUT = 1;
  localparam int IRQ_READY   = 2;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WAIT_RDY = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_ACCUM    = 3'd3,
    ST_DONE     = 3'd4
  } state_e;

endpackage

// File: rtl/hx711_shifter.sv
// One HX711 conversion: PD_SCK generation, 24-bit MSB-first capture, then the
// GAIN_PULSES extra pulses that select the gain/channel of the next conversion.
module hx711_shifter
  import hx711_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int GAIN_PULSES = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 abort_i,
  input  logic                 dsync_i,
  output logic                 sck_o,
  output logic                 done_o,
  output logic [DATA_BITS-1:0] data_o
);

  localparam int LAST_PULSE = DATA_BITS + GAIN_PULSES - 1;

  logic                 active_q, active_d;
  logic                 sck_q, sck_d;
  logic [7:0]           div_q, div_d;
  logic [4:0]           pulse_q, pulse_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 phase_end;

  assign phase_end = (div_q == 8'(CLK_DIV - 1));

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    active_d = active_q;
    sck_d    = sck_q;
    div_d    = div_q;
    pulse_d  = pulse_q;
    data_d   = data_q;
    done_o   = 1'b0;
    if (abort_i) begin
      active_d = 1'b0;
      sck_d    = 1'b0;
      div_d    = '0;
      pulse_d  = '0;
    end else if (start_i) begin
      active_d = 1'b1;
      sck_d    = 1'b1;
      div_d    = '0;
      pulse_d  = '0;
    end else if (active_q) begin
      if (!phase_end) begin
        div_d = div_q + 8'd1;
      end else begin
        div_d = '0;
        if (sck_q) begin
          // Sample on the last high-phase cycle; gain pulses carry no data.
          sck_d = 1'b0;
          if (pulse_q < 5'(DATA_BITS)) data_d = {data_q[DATA_BITS-2:0], dsync_i};
        end else if (pulse_q == 5'(LAST_PULSE)) begin
          active_d = 1'b0;
          done_o   = 1'b1;
        end else begin
          pulse_d = pulse_q + 5'd1;
          sck_d   = 1'b1;
        end
      end
    end
  end

  // NOTE: state flops use non-blocking assignments so every register updates together on the edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      sck_q    <= 1'b0;
      div_q    <= '0;
      pulse_q  <= '0;
      data_q   <= '0;
    end else begin
      active_q <= active_d;
      sck_q    <= sck_d;
      div_q    <= div_d;
      pulse_q  <= pulse_d;
      data_q   <= data_d;
    end
  end

  assign sck_o  = sck_q;
  assign data_o = data_q;

endmodule

// File: rtl/hx711_capture_core.sv
// HX711 load-cell capture: averages 2^AVG_LOG2 samples per start and raises status/irq.
// Optional HX711_CONTINUOUS_EN: keep re-running while ctrl_enable stays high.
module hx711_capture_core
  import hx711_pkg::*;
#(
  parameter int CLK_DIV     = 8,
  parameter int GAIN_PULSES = 1,
  parameter int AVG_LOG2    = 0,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        ctrl_enable,
  input  logic        ctrl_start,
  input  logic [2:0]  irq_en,
  input  logic        hx_dout_i,
  output logic        hx_sck_o,
  output logic [7:0]  core_status,
  output logic [23:0] result_o,
  output logic        result_valid_o,
  output logic        irq_o
);

  localparam int ACC_W = DATA_BITS + AVG_LOG2;
  localparam int CNT_W = 5;
  localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);

  state_e                   state_q, state_d;
  logic [TO_W-1:0]          tcnt_q, tcnt_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic [DATA_BITS-1:0]     result_q, result_d;
  logic                     valid_q, valid_d;
  logic                     done_q, done_d;
  logic                     timeout_q, timeout_d;
  logic                     irq_q;
  logic                     rdy_meta_q, rdy_sync_q;
  logic                     dsync, abort, shift_start, shift_done;
  logic [DATA_BITS-1:0]     shift_data;
  logic signed [ACC_W-1:0]  sample_ext;

  // The synchroniser carries the inverted DOUT so its cleared state reads "not ready".
  assign dsync      = ~rdy_sync_q;
  assign abort      = (state_q != ST_IDLE) && !ctrl_enable;
  assign sample_ext = ACC_W'($signed(shift_data));

  hx711_shifter #(
    .CLK_DIV     (CLK_DIV),
    .GAIN_PULSES (GAIN_PULSES)
  ) u_shifter (
    .clk_i   (wb_clk_i),
    .rst_i   (wb_rst_i),
    .start_i (shift_start),
    .abort_i (abort),
    .dsync_i (dsync),
    .sck_o   (hx_sck_o),
    .done_o  (shift_done),
    .data_o  (shift_data)
  );

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    result_d    = result_q;
    valid_d     = 1'b0;
    done_d      = done_q;
    timeout_d   = timeout_q;
    shift_start = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      tcnt_d  = '0;
      cnt_d   = '0;
      acc_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: if (ctrl_start && ctrl_enable) begin
          done_d    = 1'b0;
          timeout_d = 1'b0;
          tcnt_d    = '0;
          cnt_d     = '0;
          acc_d     = '0;
          state_d   = ST_WAIT_RDY;
        end
        ST_WAIT_RDY: begin
          if (!dsync) begin
            tcnt_d      = '0;
            shift_start = 1'b1;
            state_d     = ST_SHIFT;
          end else if (tcnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            tcnt_d    = '0;
            timeout_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            tcnt_d = tcnt_q + TO_W'(1);
          end
        end
        ST_SHIFT: if (shift_done) state_d = ST_ACCUM;
        ST_ACCUM: begin
          acc_d   = acc_q + sample_ext;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = (cnt_d == CNT_W'(1 << AVG_LOG2)) ? ST_DONE : ST_WAIT_RDY;
        end
        ST_DONE: begin
          result_d = DATA_BITS'(acc_q >>> AVG_LOG2);
          valid_d  = 1'b1;
          done_d   = 1'b1;
`ifdef HX711_CONTINUOUS_EN
          tcnt_d   = '0;
          cnt_d    = '0;
          acc_d    = '0;
          state_d  = ST_WAIT_RDY;
`else
          state_d  = ST_IDLE;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q    <= ST_IDLE;
      tcnt_q     <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      irq_q      <= 1'b0;
      rdy_meta_q <= 1'b0;
      rdy_sync_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tcnt_q     <= tcnt_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      irq_q      <= (irq_en[IRQ_DONE] & done_q) | (irq_en[IRQ_TIMEOUT] & timeout_q)
                  | (irq_en[IRQ_READY] & rdy_sync_q);
      rdy_meta_q <= ~hx_dout_i;
      rdy_sync_q <= rdy_meta_q;
    end
  end

  always_comb begin
    core_status                        = '0;
    core_status[STS_BUSY]              = (state_q != ST_IDLE);
    core_status[STS_DONE]              = done_q;
    core_status[STS_TIMEOUT]           = timeout_q;
    core_status[STS_READY]             = rdy_sync_q;
    core_status[STS_CNT_LSB +: 4]      = cnt_q[3:0];
  end

  assign result_o       = result_q;
  assign result_valid_o = valid_q;
  assign irq_o          = irq_q;

endmodule

// File: tb/tb_hx711_capture_core.sv
// Self-checking bench for hx711_capture_core with a behavioural HX711 sensor model.
// Build with +define+HX711_CONTINUOUS_EN to also exercise continuous mode.
module tb_hx711_capture_core;

  localparam int CLK_DIV     = 4;
  localparam int GAIN_PULSES = 1;
  localparam int AVG_LOG2    = 2;
  localparam int TIMEOUT_CYC = 100;
  localparam int NSAMP       = 1 << AVG_LOG2;
  localparam int PULSES      = 24 + GAIN_PULSES;
`ifdef HX711_CONTINUOUS_EN
  localparam bit CONT = 1'b1;
`else
  localparam bit CONT = 1'b0;
`endif
  // Status seen with result_valid_o, and status once idle after the run has been stopped.
  localparam logic [7:0] STS_AT_VALID = CONT ? 8'h03 : (8'(NSAMP << 4) | 8'h02);
  localparam logic [7:0] STS_STOPPED  = CONT ? 8'h02 : (8'(NSAMP << 4) | 8'h02);

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        ctrl_enable = 1'b0;
  logic        ctrl_start = 1'b0;
  logic [2:0]  irq_en = 3'b000;
  logic        hx_dout_i;
  logic        hx_sck_o;
  logic [7:0]  core_status;
  logic [23:0] result_o;
  logic        result_valid_o;
  logic        irq_o;

  int total = 0;
  int bad   = 0;

  always #5 wb_clk_i = ~wb_clk_i;

  hx711_capture_core #(
    .CLK_DIV     (CLK_DIV),
    .GAIN_PULSES (GAIN_PULSES),
    .AVG_LOG2    (AVG_LOG2),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .wb_clk_i       (wb_clk_i),
    .wb_rst_i       (wb_rst_i),
    .ctrl_enable    (ctrl_enable),
    .ctrl_start     (ctrl_start),
    .irq_en         (irq_en),
    .hx_dout_i      (hx_dout_i),
    .hx_sck_o       (hx_sck_o),
    .core_status    (core_status),
    .result_o       (result_o),
    .result_valid_o (result_valid_o),
    .irq_o          (irq_o)
  );

  // Words the sensor will deliver, in order; only the stimulus process writes these.
  logic [23:0] feed [256];
  int feed_wr   = 0;
  int flush_req = 0;

  // Observations made by the sensor/monitor process only.
  int rises = 0, hi_bad = 0, lo_bad = 0, valid_cnt = 0;

  // Sensor model: DOUT idles high, falls when a word is ready, presents the next bit
  // after each SCK rise, and returns high on the gain pulses.
  initial begin
    int sen_state = 0, sen_delay = 0, sen_bit = 0, feed_rd = 0, flush_ack = 0;
    int hi_len = 0, lo_len = 0;
    logic sck_prev = 1'b0;
    logic [23:0] sen_word = '0;
    hx_dout_i = 1'b1;
    forever begin
      @(negedge wb_clk_i);
      if (result_valid_o === 1'b1) valid_cnt++;
      if (hx_sck_o && !sck_prev) begin
        rises++;
        if (sen_state == 2 && sen_bit > 0 && lo_len != CLK_DIV) lo_bad++;
        hi_len = 1;
      end else if (hx_sck_o) begin
        hi_len++;
      end else if (sck_prev) begin
        if (hi_len != CLK_DIV) hi_bad++;
        lo_len = 1;
      end else begin
        lo_len++;
      end
      if (flush_req != flush_ack) begin
        flush_ack = flush_req;
        feed_rd   = feed_wr;
        sen_state = 0;
        hx_dout_i = 1'b1;
      end else begin
        case (sen_state)
          0: begin
            hx_dout_i = 1'b1;
            if (feed_rd != feed_wr) begin
              sen_word  = feed[feed_rd % 256];
              feed_rd++;
              sen_delay = $urandom_range(6, 20);
              sen_state = 1;
            end
          end
          1: begin
            if (sen_delay == 0) begin
              hx_dout_i = 1'b0;
              sen_bit   = 0;
              sen_state = 2;
            end else begin
              sen_delay--;
            end
          end
          default: begin
            if (hx_sck_o && !sck_prev) begin
              hx_dout_i = (sen_bit < 24) ? sen_word[23 - sen_bit] : 1'b1;
              sen_bit++;
              if (sen_bit == PULSES) sen_state = 0;
            end
          end
        endcase
      end
      sck_prev = hx_sck_o;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge wb_clk_i);
  endtask

  task automatic push(input logic [23:0] v);
    feed[feed_wr % 256] = v;
    feed_wr++;
  endtask

  task automatic flush_sensor;
    flush_req++;
    tick(3);
  endtask

  task automatic pulse_start;
    ctrl_start = 1'b1;
    tick();
    ctrl_start = 1'b0;
  endtask

  task automatic end_run;
    ctrl_enable = 1'b0;
    tick(2);
    ctrl_enable = 1'b1;
    tick();
  endtask

  task automatic wait_valid(input int budget, input string tag, output bit ok);
    int n = 0;
    while (result_valid_o !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    ok = (result_valid_o === 1'b1);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: no result_valid_o within %0d cycles", tag, budget);
    end
  endtask

  task automatic wait_rises(input int base, input int target, input string tag, output bit ok);
    int n = 0;
    while ((rises - base) < target && n < 3000) begin
      tick();
      n++;
    end
    ok = ((rises - base) >= target);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: saw %0d SCK pulses, need %0d", tag, rises - base, target);
    end
  endtask

  // Reference average: sum of signed samples divided by the count, rounded toward -inf.
  function automatic logic [23:0] floor_avg(input logic [23:0] w [NSAMP]);
    int sum = 0;
    int q;
    for (int i = 0; i < NSAMP; i++) sum += int'($signed(w[i]));
    q = sum / NSAMP;
    if ((sum % NSAMP) != 0 && sum < 0) q -= 1;
    return 24'(q);
  endfunction

  task automatic test_reset;
    tick(3);
    total++;
    if ({hx_sck_o, core_status, result_o, result_valid_o, irq_o} !== 35'd0) begin
      bad++;
      $display("FAIL reset_hold: outputs=%h want 0", {hx_sck_o, core_status, result_o, result_valid_o, irq_o});
    end
    wb_rst_i = 1'b0;
    tick(3);
    ctrl_enable = 1'b1;
    total++;
    if (core_status !== 8'h00 || hx_sck_o !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: status=%h sck=%b want 00/0", core_status, hx_sck_o);
    end
  endtask

  task automatic test_ready;
    int n = 0;
    irq_en = 3'b100;
    push(24'h000001);
    while (hx_dout_i !== 1'b0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    total++;
    if (core_status[3] !== 1'b0) begin
      bad++;
      $display("FAIL ready_latency: ready=%b one cycle after DOUT low, want 0", core_status[3]);
    end
    tick();
    total++;
    if (core_status[3] !== 1'b1) begin
      bad++;
      $display("FAIL ready_set: ready=%b two cycles after DOUT low, want 1", core_status[3]);
    end
    tick();
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("FAIL ready_irq: irq=%b want 1", irq_o);
    end
    flush_sensor();
    tick(3);
    total++;
    if (core_status[3] !== 1'b0 || irq_o !== 1'b0) begin
      bad++;
      $display("FAIL ready_clear: ready=%b irq=%b want 0/0", core_status[3], irq_o);
    end
    irq_en = 3'b000;
  endtask

  task automatic test_single;
    int r0 = rises, h0 = hi_bad, l0 = lo_bad, v0 = valid_cnt;
    bit ok;
    for (int i = 0; i < NSAMP; i++) push(24'h123456);
    pulse_start();
    wait_valid(3000, "single_valid", ok);
    if (ok) begin
      total++;
      if (result_o !== 24'h123456) begin
        bad++;
        $display("FAIL single_result: got %h want 123456", result_o);
      end
      total++;
      if (core_status !== STS_AT_VALID) begin
        bad++;
        $display("FAIL single_status: got %h want %h", core_status, STS_AT_VALID);
      end
    end
    end_run();
    tick(20);
    total++;
    if (rises - r0 != NSAMP * PULSES) begin
      bad++;
      $display("FAIL single_pulses: got %0d want %0d", rises - r0, NSAMP * PULSES);
    end
    total++;
    if (hi_bad != h0 || lo_bad != l0) begin
      bad++;
      $display("FAIL single_phase: bad high=%0d low=%0d want 0/0", hi_bad - h0, lo_bad - l0);
    end
    total++;
    if (valid_cnt - v0 != 1) begin
      bad++;
      $display("FAIL single_valid_count: got %0d want 1", valid_cnt - v0);
    end
  endtask

  task automatic test_average;
    logic [23:0] w [NSAMP];
    logic [23:0] exp_res;
    logic [15:0] seqv, exp_seq;
    logic [3:0]  prev;
    int n, cyc;
    exp_seq = '0;
    for (int i = 1; i <= NSAMP; i++) exp_seq = {exp_seq[11:0], 4'(i)};
    for (int it = 0; it < 4; it++) begin
      for (int i = 0; i < NSAMP; i++) begin
        w[i] = (it == 0) ? 24'(-(i + 1)) : 24'($urandom);
        push(w[i]);
      end
      exp_res = floor_avg(w);
      pulse_start();
      n = 0;
      cyc = 0;
      seqv = '0;
      prev = core_status[7:4];
      while (result_valid_o !== 1'b1 && cyc < 3000) begin
        tick();
        cyc++;
        if (core_status[7:4] != prev) begin
          prev = core_status[7:4];
          if (prev != 4'd0) begin
            seqv = {seqv[11:0], prev};
            n++;
          end
        end
      end
      total++;
      if (result_valid_o !== 1'b1 || result_o !== exp_res) begin
        bad++;
        $display("FAIL avg_result[%0d]: got %h valid=%b want %h", it, result_o, result_valid_o, exp_res);
      end
      total++;
      if (n != NSAMP || seqv !== exp_seq) begin
        bad++;
        $display("FAIL avg_count_seq[%0d]: got %0d steps %h want %h", it, n, seqv, exp_seq);
      end
      total++;
      if (core_status[1] !== 1'b1) begin
        bad++;
        $display("FAIL avg_done[%0d]: done=%b want 1", it, core_status[1]);
      end
      end_run();
    end
  endtask

  task automatic test_timeout;
    logic [23:0] res0 = result_o;
    int r0 = rises;
    int cyc = 1;
    irq_en = 3'b010;
    pulse_start();
    while (core_status[2] !== 1'b1 && cyc < 300) begin
      tick();
      cyc++;
    end
    total++;
    if (core_status[2] !== 1'b1 || cyc < TIMEOUT_CYC - 5 || cyc > TIMEOUT_CYC + 10) begin
      bad++;
      $display("FAIL timeout_time: timeout=%b after %0d cycles want 1 after ~%0d", core_status[2], cyc, TIMEOUT_CYC);
    end
    total++;
    if (core_status[0] !== 1'b0 || core_status[1] !== 1'b0 || irq_o !== 1'b0) begin
      bad++;
      $display("FAIL timeout_state: busy=%b done=%b irq=%b want 0/0/0", core_status[0], core_status[1], irq_o);
    end
    tick();
    total++;
    if (irq_o !== 1'b1) begin
      bad++;
      $display("FAIL timeout_irq: irq=%b want 1", irq_o);
    end
    total++;
    if (rises != r0 || result_o !== res0) begin
      bad++;
      $display("FAIL timeout_side: pulses=%0d result=%h want 0 and %h", rises - r0, result_o, res0);
    end
    irq_en = 3'b000;
  endtask

  task automatic test_abort;
    logic [23:0] w [NSAMP];
    logic [23:0] res0 = result_o;
    int r0 = rises, v0 = valid_cnt;
    bit ok;
    for (int i = 0; i < NSAMP; i++) push(24'($urandom));
    pulse_start();
    wait_rises(r0, 10, "abort_reach", ok);
    ctrl_enable = 1'b0;
    tick();
    total++;
    if (hx_sck_o !== 1'b0 || core_status[0] !== 1'b0 || core_status[1] !== 1'b0) begin
      bad++;
      $display("FAIL abort_stop: sck=%b busy=%b done=%b want 0/0/0", hx_sck_o, core_status[0], core_status[1]);
    end
    tick(20);
    flush_sensor();
    total++;
    if (valid_cnt != v0 || result_o !== res0 || core_status[7:4] !== 4'd0) begin
      bad++;
      $display("FAIL abort_side: valids=%0d result=%h cnt=%0d want 0, %h, 0", valid_cnt - v0, result_o, core_status[7:4], res0);
    end
    ctrl_enable = 1'b1;
    tick();
    for (int i = 0; i < NSAMP; i++) begin
      w[i] = 24'($urandom);
      push(w[i]);
    end
    pulse_start();
    wait_valid(3000, "abort_rerun", ok);
    total++;
    if (result_o !== floor_avg(w)) begin
      bad++;
      $display("FAIL abort_rerun_result: got %h want %h", result_o, floor_avg(w));
    end
    end_run();
  endtask

  task automatic test_ignore_start;
    logic [23:0] w [NSAMP];
    int r0 = rises, h0 = hi_bad, l0 = lo_bad, v0 = valid_cnt;
    bit ok;
    for (int i = 0; i < NSAMP; i++) begin
      w[i] = 24'($urandom);
      push(w[i]);
    end
    pulse_start();
    wait_rises(r0, 5, "ignore_reach", ok);
    pulse_start();
    wait_valid(3000, "ignore_valid", ok);
    total++;
    if (result_o !== floor_avg(w)) begin
      bad++;
      $display("FAIL ignore_result: got %h want %h", result_o, floor_avg(w));
    end
    total++;
    if (rises - r0 != NSAMP * PULSES || hi_bad != h0 || lo_bad != l0) begin
      bad++;
      $display("FAIL ignore_pulses: got %0d (bad %0d/%0d) want %0d", rises - r0, hi_bad - h0, lo_bad - l0, NSAMP * PULSES);
    end
    ctrl_enable = 1'b0;
    tick(3);
    pulse_start();
    tick(10);
    total++;
    if (core_status !== STS_STOPPED || valid_cnt - v0 != 1) begin
      bad++;
      $display("FAIL ignore_disabled: status=%h valids=%0d want %h and 1", core_status, valid_cnt - v0, STS_STOPPED);
    end
    ctrl_enable = 1'b1;
    tick();
  endtask

  task automatic test_async_reset;
    int r0 = rises;
    bit ok;
    for (int i = 0; i < NSAMP; i++) push(24'($urandom));
    pulse_start();
    wait_rises(r0, 3, "areset_reach", ok);
    #2;
    wb_rst_i = 1'b1;
    #1;
    total++;
    if ({hx_sck_o, core_status, result_o, result_valid_o, irq_o} !== 35'd0) begin
      bad++;
      $display("FAIL async_reset: outputs=%h want 0 before next edge", {hx_sck_o, core_status, result_o, result_valid_o, irq_o});
    end
    tick(2);
    wb_rst_i = 1'b0;
    flush_sensor();
  endtask

`ifdef HX711_CONTINUOUS_EN
  task automatic test_continuous;
    logic [23:0] w0 [NSAMP];
    logic [23:0] w1 [NSAMP];
    int v0 = valid_cnt;
    bit ok;
    for (int i = 0; i < NSAMP; i++) begin
      w0[i] = 24'($urandom);
      push(w0[i]);
    end
    for (int i = 0; i < NSAMP; i++) begin
      w1[i] = 24'($urandom);
      push(w1[i]);
    end
    pulse_start();
    wait_valid(3000, "cont_first", ok);
    total++;
    if (result_o !== floor_avg(w0)) begin
      bad++;
      $display("FAIL cont_first_result: got %h want %h", result_o, floor_avg(w0));
    end
    tick();
    wait_valid(3000, "cont_second", ok);
    total++;
    if (result_o !== floor_avg(w1)) begin
      bad++;
      $display("FAIL cont_second_result: got %h want %h", result_o, floor_avg(w1));
    end
    end_run();
    tick(20);
    total++;
    if (valid_cnt - v0 != 2) begin
      bad++;
      $display("FAIL cont_valid_count: got %0d want 2", valid_cnt - v0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_ready();
    test_single();
    test_average();
    test_timeout();
    test_abort();
    test_ignore_start();
    test_async_reset();
`ifdef HX711_CONTINUOUS_EN
    ctrl_enable = 1'b1;
    tick(2);
    test_continuous();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
